// File: rtl/axi_switch_pkg.sv
// Shared types and helpers for the AXI4 switch: ID-table entry layout,
// width derivation functions, and the AXI response encodings.
// No logic; imported by the tracker, its interface and the arbiter.
package axi_switch_pkg;

    // Index width that still works for a single requester (never zero-width).
    function automatic int f_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int f_log_m(input int m);
        return f_idx_w(m);
    endfunction

    function automatic int f_cnt_w(input int max_out);
        return $clog2(max_out + 1);
    endfunction

    // Switch-wide configuration; the ID-table entry layout is sized from these.
    localparam int SW_M        = 2;
    localparam int SW_N        = 2;
    localparam int SW_ID_WIDTH = 4;
    localparam int SW_MAX_OUT  = 4;
    localparam int SW_LOG_M    = f_log_m(SW_M);
    localparam int SW_CNT_W    = f_cnt_w(SW_MAX_OUT);

    typedef struct packed {
        logic [SW_LOG_M-1:0] owner;
        logic [SW_CNT_W-1:0] cnt;
    } id_entry_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

endpackage

// File: rtl/axi_id_tracker_if.sv
// Bundle of the tracker's request, release, lookup and status signals.
// slave modport = tracker side, master modport = switch/bench side.
// occ_o/peak_o exist only when AXI_ID_TRACKER_STATS_EN is defined.
interface axi_id_tracker_if
    import axi_switch_pkg::*;
#(
    parameter int M        = SW_M,
    parameter int N        = SW_N,
    parameter int ID_WIDTH = SW_ID_WIDTH,
    parameter int MAX_OUT  = SW_MAX_OUT
);
    localparam int LOG_M = f_log_m(M);

    logic                         req_vld_i;
    logic                         req_rdy_o;
    logic [ID_WIDTH-1:0]          req_id_i;
    logic [LOG_M-1:0]             req_src_i;
    logic [N-1:0]                 lkp_req_i;
    logic [N-1:0][ID_WIDTH-1:0]   lkp_id_i;
    logic [N-1:0]                 lkp_gnt_o;
    logic [LOG_M-1:0]             lkp_dst_o;
    logic                         lkp_hit_o;
    logic                         rel_vld_i;
    logic [ID_WIDTH-1:0]          rel_id_i;
    logic                         err_o;
`ifdef AXI_ID_TRACKER_STATS_EN
    localparam int CNT_W = f_cnt_w(MAX_OUT);
    logic [ID_WIDTH+CNT_W-1:0]    occ_o;
    logic [ID_WIDTH+CNT_W-1:0]    peak_o;
`endif

    modport slave (
        input  req_vld_i, req_id_i, req_src_i,
        input  lkp_req_i, lkp_id_i,
        input  rel_vld_i, rel_id_i,
        output req_rdy_o, lkp_gnt_o, lkp_dst_o, lkp_hit_o,
`ifdef AXI_ID_TRACKER_STATS_EN
        output occ_o, peak_o,
`endif
        output err_o
    );

    modport master (
        output req_vld_i, req_id_i, req_src_i,
        output lkp_req_i, lkp_id_i,
        output rel_vld_i, rel_id_i,
        input  req_rdy_o, lkp_gnt_o, lkp_dst_o, lkp_hit_o,
`ifdef AXI_ID_TRACKER_STATS_EN
        input  occ_o, peak_o,
`endif
        input  err_o
    );

endinterface

// File: rtl/axi_id_tracker_rr_arbiter.sv
// Round-robin arbiter: one-hot grant over N requesters, pointer moves past winner.
// Latency 0: grant/winner are combinational from req_i and the registered pointer.
// No backpressure; a requester left asserted is simply re-arbitrated.
// Ports: clk, rst (sync, active-high); req_i[N]; gnt_o[N] one-hot; win_o index; vld_o any grant.
module rr_arbiter
    import axi_switch_pkg::*;
#(
    parameter int N = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           req_i,
    output logic [N-1:0]           gnt_o,
    output logic [f_idx_w(N)-1:0]  win_o,
    output logic                   vld_o
);
    localparam int IDX_W = f_idx_w(N);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] win_c;
    logic             vld_c;
    int               idx;

    // Scan starting at the pointer slot; first asserted request wins.
    always_comb begin
        win_c = '0;
        vld_c = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!vld_c && req_i[IDX_W'(idx)]) begin
                vld_c = 1'b1;
                win_c = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        gnt_o = '0;
        if (vld_c) gnt_o[win_c] = 1'b1;
        win_o = win_c;
        vld_o = vld_c;
        ptr_d = ptr_q;
        if (vld_c) ptr_d = (win_c == IDX_W'(N - 1)) ? '0 : win_c + IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/axi_id_tracker.sv
// Per-direction AXI ID tracker: owner/count table, conflict stall, routed response lookups.
// Latency: table update visible 1 cycle after handshake; lookup result 1 cycle after request.
// Backpressure: req_rdy_o drops on ID owned by another master or count at MAX_OUT.
// Ports: clk, rst (sync, active-high); bus = axi_id_tracker_if.slave (request, release,
// lookup, err). Optional AXI_ID_TRACKER_STATS_EN adds occ_o/peak_o occupancy counters.
module axi_id_tracker
    import axi_switch_pkg::*;
#(
    parameter int M        = SW_M,
    parameter int N        = SW_N,
    parameter int ID_WIDTH = SW_ID_WIDTH,
    parameter int MAX_OUT  = SW_MAX_OUT
) (
    input  logic                clk,
    input  logic                rst,
    axi_id_tracker_if.slave     bus
);
    localparam int LOG_M = f_log_m(M);
    localparam int CNT_W = f_cnt_w(MAX_OUT);
    localparam int DEPTH = 2 ** ID_WIDTH;
    localparam int IDX_W = f_idx_w(N);

    // Flop array: one lookup read plus request and release updates every cycle.
    id_entry_t ent_q [DEPTH];
    id_entry_t ent_d [DEPTH];

    id_entry_t req_ent, rel_ent, lkp_ent;
    logic      acc, rel_ok, rel_bad, same_id;

    logic [N-1:0]     arb_gnt;
    logic [IDX_W-1:0] arb_win;
    logic             arb_vld;
    logic             lkp_hit_c;

    logic [N-1:0]     gnt_q, gnt_d;
    logic [LOG_M-1:0] dst_q, dst_d;
    logic             hit_q, hit_d;
    logic             err_q, err_d;

    assign req_ent = ent_q[bus.req_id_i];
    assign rel_ent = ent_q[bus.rel_id_i];

    assign bus.req_rdy_o = (req_ent.cnt == '0) ||
                           ((req_ent.owner == bus.req_src_i) && (req_ent.cnt < CNT_W'(MAX_OUT)));

    assign acc     = bus.req_vld_i && bus.req_rdy_o;
    assign rel_ok  = bus.rel_vld_i && (rel_ent.cnt != '0);
    assign rel_bad = bus.rel_vld_i && (rel_ent.cnt == '0);
    assign same_id = (bus.req_id_i == bus.rel_id_i);

    // An accept and a valid release of the same ID cancel out; the owner
    // cannot change in that case because acceptance required a match.
    always_comb begin
        ent_d = ent_q;
        if (acc && !(rel_ok && same_id)) begin
            if (req_ent.cnt == '0) ent_d[bus.req_id_i].owner = bus.req_src_i;
            ent_d[bus.req_id_i].cnt = req_ent.cnt + CNT_W'(1);
        end
        if (rel_ok && !(acc && same_id)) begin
            ent_d[bus.rel_id_i].cnt = rel_ent.cnt - CNT_W'(1);
        end
    end

    rr_arbiter #(.N(N)) u_lkp_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i (bus.lkp_req_i),
        .gnt_o (arb_gnt),
        .win_o (arb_win),
        .vld_o (arb_vld)
    );

    // Lookup reads the pre-update entry, so a same-cycle accept is not seen.
    assign lkp_ent   = ent_q[bus.lkp_id_i[arb_win]];
    assign lkp_hit_c = arb_vld && (lkp_ent.cnt != '0);

    always_comb begin
        gnt_d = arb_gnt;
        dst_d = lkp_hit_c ? lkp_ent.owner : '0;
        hit_d = lkp_hit_c;
        err_d = err_q | rel_bad | (arb_vld & ~lkp_hit_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            gnt_q <= '0;
            dst_q <= '0;
            hit_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ent_q <= ent_d;
            gnt_q <= gnt_d;
            dst_q <= dst_d;
            hit_q <= hit_d;
            err_q <= err_d;
        end
    end

    assign bus.lkp_gnt_o = gnt_q;
    assign bus.lkp_dst_o = dst_q;
    assign bus.lkp_hit_o = hit_q;
    assign bus.err_o     = err_q;

`ifdef AXI_ID_TRACKER_STATS_EN
    localparam int OCC_W = ID_WIDTH + CNT_W;

    logic [OCC_W-1:0] occ_q, occ_d;
    logic [OCC_W-1:0] peak_q, peak_d;

    always_comb begin
        occ_d  = occ_q + OCC_W'(acc) - OCC_W'(rel_ok);
        peak_d = (occ_d > peak_q) ? occ_d : peak_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q  <= '0;
            peak_q <= '0;
        end else begin
            occ_q  <= occ_d;
            peak_q <= peak_d;
        end
    end

    assign bus.occ_o  = occ_q;
    assign bus.peak_o = peak_q;
`endif

endmodule

// File: tb/tb_axi_id_tracker.sv
// Scoreboard bench for axi_id_tracker: directed scenarios then randomized traffic.
// Driver acts on the falling edge and updates an ID-table reference model;
// a monitor checks lookups, err and stats just after each rising edge.
module tb_axi_id_tracker;

    localparam int N       = 2;
    localparam int MAX_OUT = 4;
    localparam int NID     = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_id_tracker_if bus ();
    axi_id_tracker dut (.clk(clk), .rst(rst), .bus(bus));

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    // Reference model
    int m_cnt [NID];
    int m_own [NID];
    bit m_err;
    int m_ptr;
    int m_occ, m_peak;

    typedef struct {
        int cyc;
        int gnt;
        int dst;
        int hit;
    } exp_t;
    exp_t exp_q [$];

    bit pend    [N];
    int pend_id [N];

    // Stimulus intents for the next cycle
    bit d_vld, d_rel, d_rst, rnd_lkp;
    int d_id, d_src, d_relid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_rdy(input int id, input int src);
        return (m_cnt[id] == 0) || ((m_own[id] == src) && (m_cnt[id] < MAX_OUT));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NID; i++) begin
            m_cnt[i] = 0;
            m_own[i] = 0;
        end
        m_err = 0; m_ptr = 0; m_occ = 0; m_peak = 0;
        exp_q.delete();
        for (int s = 0; s < N; s++) pend[s] = 0;
    endtask

    task automatic tick();
        logic [N-1:0]      lreq;
        logic [N-1:0][3:0] lid;
        bit rdy, acc;
        int pre_rel, w, id;
        @(negedge clk);
        // A requester drops its request in the cycle its grant is visible.
        for (int s = 0; s < N; s++) if (bus.lkp_gnt_o[s]) pend[s] = 0;
        if (rnd_lkp && !d_rst) begin
            for (int s = 0; s < N; s++) begin
                if (!pend[s] && !bus.lkp_gnt_o[s] && $urandom_range(0, 3) == 0) begin
                    pend[s]    = 1;
                    pend_id[s] = $urandom_range(0, 3);
                end
            end
        end
        if (d_rst) for (int s = 0; s < N; s++) pend[s] = 0;
        for (int s = 0; s < N; s++) begin
            lreq[s] = pend[s];
            lid[s]  = 4'(pend_id[s]);
        end
        rst           = d_rst;
        bus.req_vld_i = d_vld;
        bus.req_id_i  = 4'(d_id);
        bus.req_src_i = 1'(d_src);
        bus.rel_vld_i = d_rel;
        bus.rel_id_i  = 4'(d_relid);
        bus.lkp_req_i = lreq;
        bus.lkp_id_i  = lid;
        #1;
        rdy = m_rdy(d_id, d_src);
        chk("req_rdy", {31'd0, bus.req_rdy_o}, {31'd0, rdy});
        if (d_rst) begin
            model_reset();
        end else begin
            if (lreq != '0) begin
                w = -1;
                for (int k = 0; k < N; k++) begin
                    if (w < 0 && lreq[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                end
                id = pend_id[w];
                if (m_cnt[id] > 0) exp_q.push_back('{cyc + 1, 1 << w, m_own[id], 1});
                else begin
                    exp_q.push_back('{cyc + 1, 1 << w, 0, 0});
                    m_err = 1;
                end
                m_ptr = (w + 1) % N;
            end
            acc     = d_vld && rdy;
            pre_rel = m_cnt[d_relid];
            if (acc) begin
                if (m_cnt[d_id] == 0) m_own[d_id] = d_src;
                m_cnt[d_id]++;
                m_occ++;
            end
            if (d_rel) begin
                if (pre_rel > 0) begin
                    m_cnt[d_relid]--;
                    m_occ--;
                end else m_err = 1;
            end
            if (m_occ > m_peak) m_peak = m_occ;
        end
        d_vld = 0; d_rel = 0; d_rst = 0;
    endtask

    // Monitor: compare DUT outputs against scoreboard after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                chk("lkp_gnt", 32'(bus.lkp_gnt_o), e.gnt);
                chk("lkp_dst", 32'(bus.lkp_dst_o), e.dst);
                chk("lkp_hit", 32'(bus.lkp_hit_o), e.hit);
            end else begin
                chk("lkp_idle_gnt", 32'(bus.lkp_gnt_o), 0);
            end
            chk("err", 32'(bus.err_o), {31'd0, m_err});
`ifdef AXI_ID_TRACKER_STATS_EN
            chk("occ", 32'(bus.occ_o), m_occ);
            chk("peak", 32'(bus.peak_o), m_peak);
`endif
        end
    end

    task automatic set_req(input bit vld, input int id, input int src);
        d_vld = vld; d_id = id; d_src = src;
    endtask

    initial begin
        bus.req_vld_i = 0; bus.req_id_i = 0; bus.req_src_i = 0;
        bus.rel_vld_i = 0; bus.rel_id_i = 0;
        bus.lkp_req_i = '0; bus.lkp_id_i = '0;
        d_vld = 0; d_rel = 0; d_id = 0; d_src = 0; d_relid = 0; rnd_lkp = 0;
        for (int s = 0; s < N; s++) pend_id[s] = 0;
        model_reset();

        // Reset state
        d_rst = 1; tick();
        tick();
        chk("rst_gnt", 32'(bus.lkp_gnt_o), 0);
        chk("rst_dst", 32'(bus.lkp_dst_o), 0);
        chk("rst_hit", 32'(bus.lkp_hit_o), 0);
        chk("rst_err", 32'(bus.err_o), 0);
        chk("rst_rdy", 32'(bus.req_rdy_o), 1);

        // Ownership: id 3 taken by master 1
        set_req(1, 3, 1); tick();
        set_req(0, 3, 1); tick();
        chk("owner_rdy", 32'(bus.req_rdy_o), 1);
        set_req(0, 3, 0); tick();
        chk("other_stall", 32'(bus.req_rdy_o), 0);

        // Saturation of id 5 by master 0
        for (int i = 0; i < 4; i++) begin
            set_req(1, 5, 0); tick();
        end
        set_req(0, 5, 0); tick();
        chk("sat_rdy", 32'(bus.req_rdy_o), 0);
        d_rel = 1; d_relid = 5; set_req(0, 5, 0); tick();
        set_req(0, 5, 0); tick();
        chk("unsat_rdy", 32'(bus.req_rdy_o), 1);

        // Same-cycle accept and release of id 2
        set_req(1, 2, 0); tick();
        d_rel = 1; d_relid = 2; set_req(1, 2, 0); tick();
        d_rel = 1; d_relid = 2; set_req(1, 2, 1); tick();
        chk("same_cyc_stall", 32'(bus.req_rdy_o), 0);
        set_req(0, 2, 1); tick();
        chk("after_rel_rdy", 32'(bus.req_rdy_o), 1);

        // Lookup contention: slave0 -> id 3 (master 1), slave1 -> id 5 (master 0)
        set_req(0, 0, 0);
        pend[0] = 1; pend_id[0] = 3;
        pend[1] = 1; pend_id[1] = 5;
        tick();
        tick();
        chk("arb_first_gnt", 32'(bus.lkp_gnt_o), 1);
        chk("arb_first_dst", 32'(bus.lkp_dst_o), 1);
        tick();
        chk("arb_second_gnt", 32'(bus.lkp_gnt_o), 2);
        chk("arb_second_dst", 32'(bus.lkp_dst_o), 0);
        tick();
        pend[0] = 1; pend_id[0] = 3;
        pend[1] = 1; pend_id[1] = 5;
        for (int i = 0; i < 4; i++) tick();

        // Release of an idle ID
        d_rel = 1; d_relid = 7; tick();
        set_req(0, 7, 1); tick();
        chk("rel_err", 32'(bus.err_o), 1);
        chk("idle_rdy", 32'(bus.req_rdy_o), 1);

        // Lookup of an empty ID after reset
        d_rst = 1; tick();
        tick();
        chk("rst_err_clear", 32'(bus.err_o), 0);
        pend[0] = 1; pend_id[0] = 9;
        tick();
        tick();
        chk("miss_gnt", 32'(bus.lkp_gnt_o), 1);
        chk("miss_hit", 32'(bus.lkp_hit_o), 0);
        chk("miss_dst", 32'(bus.lkp_dst_o), 0);
        chk("miss_err", 32'(bus.err_o), 1);

`ifdef AXI_ID_TRACKER_STATS_EN
        d_rst = 1; tick();
        for (int i = 0; i < 3; i++) begin
            set_req(1, 1, 0); tick();
        end
        set_req(0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            d_rel = 1; d_relid = 1; tick();
        end
        tick();
        chk("stats_occ", 32'(bus.occ_o), 1);
        chk("stats_peak", 32'(bus.peak_o), 3);
        d_rst = 1; tick();
        tick();
        chk("stats_rst_occ", 32'(bus.occ_o), 0);
        chk("stats_rst_peak", 32'(bus.peak_o), 0);
`endif

        // Randomized traffic with periodic mid-run resets
        d_rst = 1; tick();
        rnd_lkp = 1;
        for (int n = 0; n < 3000; n++) begin
            set_req($urandom_range(0, 9) < 7, $urandom_range(0, 3), $urandom_range(0, 1));
            d_relid = $urandom_range(0, 3);
            d_rel   = ($urandom_range(0, 9) < 4) &&
                      ((m_cnt[d_relid] > 0) || ($urandom_range(0, 19) == 0));
            if (n % 700 == 699) d_rst = 1;
            tick();
        end
        rnd_lkp = 0;
        set_req(0, 0, 0);
        for (int i = 0; i < 6; i++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
